// File: rtl/gpp_apb_master.sv
// gpp_apb_master: request/response front end driving a single APB master with wait timeout and counters
module gpp_apb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr,
   output logic [15:0] txn_cnt,
   output logic [15:0] err_cnt
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   localparam bit          TO_EN     = TIMEOUT_CYCLES != 0;
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
   state_t      state_q;
   logic [15:0] wait_q;
   logic        tmo_hit;
   logic        acc_done;
   // abort when this ACCESS cycle would be the last one allowed; pready still wins
   always_comb begin
      tmo_hit  = TO_EN && !pready && wait_q == WAIT_LAST;
      acc_done = pready || tmo_hit;
   end
   // transfer FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         txn_cnt     <= '0;
         err_cnt     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready) begin
                  state_q   <= SETUP;
                  req_ready <= 1'b0;
                  psel      <= 1'b1;
                  pwrite    <= req_write;
                  paddr     <= req_addr & 32'hFFFF_FFFC;
                  pwdata    <= req_write ? req_wdata : 32'h0;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            SETUP: begin
               state_q <= ACCESS;
               penable <= 1'b1;
               wait_q  <= '0;
            end
            ACCESS: begin
               if (acc_done) begin
                  state_q     <= RESP;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= (tmo_hit || pwrite) ? 32'h0 : prdata;
                  rsp_err     <= tmo_hit || pslverr;
                  rsp_timeout <= tmo_hit;
                  txn_cnt     <= txn_cnt + 16'd1;
                  if ((tmo_hit || pslverr) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
               end else begin
                  wait_q <= wait_q + 16'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q   <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gpp_apb_master.sv
// tb_gpp_apb_master: directed checks of the APB master with a 4-cycle timeout
module tb_gpp_apb_master;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata = '0;
   logic        pready = 1'b0, pslverr = 1'b0;
   logic [15:0] txn_cnt, err_cnt;
   int          n_cmp = 0, n_bad = 0;

   gpp_apb_master #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .txn_cnt(txn_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rsp_hs();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("hs_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #2;
      chk("rst_psel", 32'(psel), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_txn", 32'(txn_cnt), 32'd0);
      chk("rst_paddr", paddr, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);

      // write, pready tied high
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1A10_0007; req_wdata = 32'hCAFE_F00D; pready = 1'b1;
      step();
      req_valid = 1'b0;
      chk("w_setup_psel", 32'(psel), 32'd1);
      chk("w_setup_penable", 32'(penable), 32'd0);
      chk("w_paddr", paddr, 32'h1A10_0004);
      chk("w_pwdata", pwdata, 32'hCAFE_F00D);
      chk("w_pwrite", 32'(pwrite), 32'd1);
      chk("w_req_ready", 32'(req_ready), 32'd0);
      step();
      chk("w_access_psel", 32'(psel), 32'd1);
      chk("w_access_penable", 32'(penable), 32'd1);
      chk("w_access_rsp_valid", 32'(rsp_valid), 32'd0);
      step();
      chk("w_resp_psel", 32'(psel), 32'd0);
      chk("w_resp_penable", 32'(penable), 32'd0);
      chk("w_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("w_rsp_err", 32'(rsp_err), 32'd0);
      chk("w_rsp_rdata", rsp_rdata, 32'd0);
      chk("w_txn", 32'(txn_cnt), 32'd1);
      pready = 1'b0;
      rsp_hs();

      // read with three wait states
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0013; req_wdata = 32'hFFFF_FFFF; prdata = 32'h1234_5678;
      step();
      req_valid = 1'b0;
      chk("r_pwdata", pwdata, 32'd0);
      chk("r_pwrite", 32'(pwrite), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("r_penable%0d", i), 32'(penable), 32'd1);
         chk($sformatf("r_paddr%0d", i), paddr, 32'h4000_0010);
         if (i == 3) pready = 1'b1;
      end
      step();
      pready = 1'b0;
      chk("r_penable_end", 32'(penable), 32'd0);
      chk("r_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("r_rsp_rdata", rsp_rdata, 32'h1234_5678);
      chk("r_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("r_txn", 32'(txn_cnt), 32'd2);
      rsp_hs();

      // timeout after four access cycles
      req_valid = 1'b1; req_addr = 32'h0000_0008;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("t_psel%0d", i), 32'(psel), 32'd1);
      end
      step();
      chk("t_psel_drop", 32'(psel), 32'd0);
      chk("t_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t_rsp_err", 32'(rsp_err), 32'd1);
      chk("t_rsp_timeout", 32'(rsp_timeout), 32'd1);
      chk("t_rsp_rdata", rsp_rdata, 32'd0);
      chk("t_err_cnt", 32'(err_cnt), 32'd1);
      chk("t_txn", 32'(txn_cnt), 32'd3);
      rsp_hs();

      // pready with pslverr on the limit cycle
      req_valid = 1'b1; req_addr = 32'h0000_000C; prdata = 32'hA5A5_0001;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 3) begin pready = 1'b1; pslverr = 1'b1; end
      end
      step();
      pready = 1'b0; pslverr = 1'b0;
      chk("e_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("e_rsp_err", 32'(rsp_err), 32'd1);
      chk("e_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      chk("e_err_cnt", 32'(err_cnt), 32'd2);

      // response back-pressure with a pending request
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'h0000_0055;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("bp_rsp_valid%0d", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp_rdata%0d", i), rsp_rdata, 32'hA5A5_0001);
         chk($sformatf("bp_req_ready%0d", i), 32'(req_ready), 32'd0);
      end
      chk("bp_rsp_err", 32'(rsp_err), 32'd1);
      rsp_hs();
      step();
      req_valid = 1'b0;
      chk("bp_next_psel", 32'(psel), 32'd1);
      chk("bp_next_paddr", paddr, 32'h0000_0010);
      pready = 1'b1;
      step();
      step();
      pready = 1'b0;
      chk("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_next_txn", 32'(txn_cnt), 32'd5);
      rsp_hs();

      // reset during ACCESS
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0020;
      step();
      req_valid = 1'b0;
      step();
      chk("ar_penable_pre", 32'(penable), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_psel", 32'(psel), 32'd0);
      chk("ar_penable", 32'(penable), 32'd0);
      chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("ar_txn", 32'(txn_cnt), 32'd0);
      chk("ar_err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("ar_req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0030; req_wdata = 32'h1111_2222; pready = 1'b1;
      step();
      req_valid = 1'b0;
      chk("ar2_pwdata", pwdata, 32'h1111_2222);
      step();
      step();
      pready = 1'b0;
      chk("ar2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("ar2_rsp_err", 32'(rsp_err), 32'd0);
      chk("ar2_txn", 32'(txn_cnt), 32'd1);
      rsp_hs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
